// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and constants for the programmable clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    typedef enum logic {
        DIV_MODE_DUTY50 = 1'b0,
        DIV_MODE_PULSE  = 1'b1
    } div_mode_e;

    // Smallest ratio that still produces a distinct high and low phase.
    localparam int MIN_DIV = 2;

endpackage : clk_div_pkg

`default_nettype wire

// File: rtl/clk_div_half_stage.sv
// ============================================================================
// Module      : clk_div_half_stage
// Description : Negedge half-cycle extension stage and odd/even duty select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_half_stage (
    input  logic clk,
    input  logic rst,
    input  logic i_pos_q,
    input  logic i_run,
    input  logic i_odd,
    output logic o_duty
);

    logic r_neg_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= i_pos_q;
        end
    end

    // Gating with run lets a disable force the output low at the posedge
    // instead of waiting for the next falling edge to clear the extension.
    assign o_duty = i_odd ? (i_pos_q | (r_neg_q & i_run)) : i_pos_q;

endmodule : clk_div_half_stage

`default_nettype wire

// File: rtl/clk_div_prog.sv
// ============================================================================
// Module      : clk_div_prog
// Description : Run-time programmable integer clock divider with 50% duty or
//               single-cycle pulse output and a ready/valid ratio interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_rdy,
    output logic             div_err,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] c_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_MIN_DIV     = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    generate
        if ((DEFAULT_DIV < MIN_DIV) || (DEFAULT_DIV > ((2 ** CNT_W) - 1))) begin : g_bad_default
            $error("clk_div_prog: DEFAULT_DIV outside legal range");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_pos_q;
    logic [CNT_W-1:0] r_div_cur;
    div_mode_e        r_mode_cur;
    logic [CNT_W-1:0] r_pending;
    logic             r_div_rdy;
    logic             r_div_err;

    logic             w_last;
    logic             w_wrap;
    logic             w_apply;
    logic             w_xfer;
    logic             w_val_ok;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic             w_pulse;
    logic             w_duty;

    assign w_last   = (r_cnt == (r_div_cur - c_ONE));
    assign w_wrap   = r_run & w_last;
    // While idle every edge is a period boundary, so a new ratio or mode
    // takes hold before the first period starts.
    assign w_apply  = w_wrap | ~r_run;
    assign w_xfer   = div_load & r_div_rdy;
    assign w_val_ok = (div_val >= c_MIN_DIV);

    always_comb begin
        w_cnt_nxt = '0;
        if (en && r_run && !w_last) begin
            w_cnt_nxt = r_cnt + c_ONE;
        end
    end

    always_comb begin
        w_div_nxt = r_div_cur;
        if (w_apply && !r_div_rdy) begin
            w_div_nxt = r_pending;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_pos_q    <= 1'b0;
            r_div_cur  <= c_DEFAULT_DIV;
            r_mode_cur <= DIV_MODE_DUTY50;
            r_pending  <= '0;
            r_div_rdy  <= 1'b1;
            r_div_err  <= 1'b0;
        end else begin
            r_run     <= en;
            r_cnt     <= w_cnt_nxt;
            r_pos_q   <= en & (w_cnt_nxt < (w_div_nxt >> 1));
            r_div_err <= w_xfer & ~w_val_ok;
            r_div_cur <= w_div_nxt;

            if (w_apply) begin
                r_mode_cur <= div_mode_e'(mode);
            end

            // Apply needs rdy low and a transfer needs rdy high, so a load
            // on the wrap cycle always waits for the following wrap.
            if (w_apply && !r_div_rdy) begin
                r_div_rdy <= 1'b1;
            end else if (w_xfer && w_val_ok) begin
                r_pending <= div_val;
                r_div_rdy <= 1'b0;
            end
        end
    end

    clk_div_half_stage u_half_stage (
        .clk     (clk),
        .rst     (rst),
        .i_pos_q (r_pos_q),
        .i_run   (r_run),
        .i_odd   (r_div_cur[0]),
        .o_duty  (w_duty)
    );

    assign w_pulse = r_run & (r_cnt == '0);

    assign clk_out = (r_mode_cur == DIV_MODE_PULSE) ? w_pulse : w_duty;
    assign tick    = w_wrap;
    assign div_rdy = r_div_rdy;
    assign div_err = r_div_err;
    assign div_cur = r_div_cur;

endmodule : clk_div_prog

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Directed and randomized self-checking bench for clk_div_prog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_rdy;
    logic       div_err;
    logic [7:0] div_cur;
    logic       clk_out;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the period, ratio and mode in force.
    bit m_run;
    int m_p;
    int m_n;
    bit m_mode;
    bit m_rdy;
    bit m_err;
    int m_pend;

    clk_div_prog #(
        .CNT_W       (8),
        .DEFAULT_DIV (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .div_val  (div_val),
        .div_load (div_load),
        .div_rdy  (div_rdy),
        .div_err  (div_err),
        .div_cur  (div_cur),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_edge();
        bit wrap;
        bit old_rdy;
        if (rst) begin
            m_run = 1'b0; m_p = 0; m_n = 7; m_mode = 1'b0;
            m_rdy = 1'b1; m_err = 1'b0; m_pend = 0;
            return;
        end
        old_rdy = m_rdy;
        wrap    = m_run && (m_p == m_n - 1);
        m_err   = div_load && old_rdy && (int'(div_val) < 2);
        if (wrap || !m_run) begin
            m_mode = mode;
            if (!old_rdy) begin
                m_n   = m_pend;
                m_rdy = 1'b1;
            end
        end
        if (div_load && old_rdy && int'(div_val) >= 2) begin
            m_pend = int'(div_val);
            m_rdy  = 1'b0;
        end
        if (!en) begin
            m_run = 1'b0; m_p = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_p = 0;
        end else begin
            m_p = wrap ? 0 : m_p + 1;
        end
    endfunction

    // Output level in half-clock units: DUTY50 is high for the first N halves.
    function automatic int exp_clk(input int half);
        if (!m_run) return 0;
        if (m_mode) return (m_p == 0) ? 1 : 0;
        return ((2 * m_p + half) < m_n) ? 1 : 0;
    endfunction

    function automatic int exp_tick();
        return (m_run && (m_p == m_n - 1)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_out_first_half", 32'(clk_out), exp_clk(0));
        chk("tick", 32'(tick), exp_tick());
        chk("div_cur", 32'(div_cur), m_n);
        chk("div_rdy", 32'(div_rdy), 32'(m_rdy));
        chk("div_err", 32'(div_err), 32'(m_err));
        @(negedge clk);
        #1;
        chk("clk_out_second_half", 32'(clk_out), exp_clk(1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < 600 && !(m_run && m_p == target); i++) cyc();
        checks++;
        assert (m_run && m_p == target) else begin
            failures++;
            $error("FAIL wait_pos observed=%0d expected=%0d", m_p, target);
        end
    endtask

    task automatic load(input int val);
        div_val  = 8'(val);
        div_load = 1'b1;
        cyc();
        div_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; div_val = 8'd0; div_load = 1'b0;
        run(3);
        rst = 1'b0;
        run(2);

        // Default N=7 at 50% duty.
        en = 1'b1;
        run(22);

        // Rejected ratios.
        load(1);
        load(0);
        run(4);

        // Ratio change requested mid-period.
        wait_pos(2);
        load(4);
        run(14);

        // Pulse mode at N=5; a brief mode toggle mid-period must not stick.
        mode = 1'b1;
        load(5);
        run(12);
        wait_pos(1);
        mode = 1'b0;
        run(2);
        mode = 1'b1;
        run(12);

        // Back to DUTY50 N=7, then disable mid-period and resume.
        mode = 1'b0;
        load(7);
        run(10);
        wait_pos(3);
        en = 1'b0;
        run(4);
        en = 1'b1;
        run(16);

        // Reset with a ratio pending, then the largest ratio.
        wait_pos(1);
        load(9);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(3);
        load(255);
        run(540);

        // Randomized traffic with short ratios.
        load(3);
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            div_load = ($urandom_range(0, 3) == 0);
            div_val  = 8'($urandom_range(0, 12));
            cyc();
        end
        rst = 1'b0; div_load = 1'b0; en = 1'b1;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clk_div_prog

`default_nettype wire
